// File: rtl/dram_arb.sv
// dram_arb: 4-clk slot arbiter/sequencer for the shared 16-bit DRAM port (video > CPU > DMA).
// Define DRAM_ARB_FAIR_EN to build the DMA anti-starvation counter (FAIR_LIMIT consecutive CPU slots).
module dram_arb #(
  parameter int unsigned FAIR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c0,
  input  logic        c1,
  input  logic        c2,
  input  logic        c3,
  input  logic        vid_slot,
  input  logic [20:0] vid_addr,
  output logic        vid_strobe,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [20:0] cpu_addr,
  input  logic        cpu_wrbsel,
  input  logic [7:0]  cpu_wrdata,
  output logic        cpu_next,
  output logic        cpu_strobe,
  output logic        cpu_latch,
  output logic [15:0] cpu_rddata,
  input  logic        dma_req,
  input  logic        dma_rnw,
  input  logic [20:0] dma_addr,
  input  logic [15:0] dma_wrdata,
  output logic        dma_next,
  output logic        dma_strobe,
  output logic [15:0] dma_rddata,
  output logic        dram_req,
  output logic        dram_rnw,
  output logic [20:0] dram_addr,
  output logic [1:0]  dram_bsel,
  output logic [15:0] dram_wrdata,
  input  logic [15:0] dram_rddata
);

  typedef enum logic [1:0] {GNT_NONE, GNT_VID, GNT_CPU, GNT_DMA} grant_t;

  grant_t grant, grant_nxt;
  logic   fair_force;
  logic   cpu_rd_slot;

`ifdef DRAM_ARB_FAIR_EN
  logic [2:0] fair_cnt;

  assign fair_force = dma_req && ({29'd0, fair_cnt} >= FAIR_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fair_cnt <= '0;
    end else if (c3) begin
      if (!dma_req || grant_nxt == GNT_DMA)
        fair_cnt <= '0;
      else if (grant_nxt == GNT_CPU && fair_cnt != '1)
        fair_cnt <= fair_cnt + 3'd1;
    end
  end
`else
  assign fair_force = 1'b0;
`endif

  always_comb begin
    grant_nxt = GNT_NONE;
    if (vid_slot)
      grant_nxt = GNT_VID;
    else if (fair_force)
      grant_nxt = GNT_DMA;
    else if (cpu_req)
      grant_nxt = GNT_CPU;
    else if (dma_req)
      grant_nxt = GNT_DMA;
  end

  assign cpu_next = !vid_slot && !fair_force;
  assign dma_next = !vid_slot && (!cpu_req || fair_force);

  // Slot transaction is latched at the c3 edge; idle slots keep the last address/data on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= GNT_NONE;
      dram_req    <= 1'b0;
      dram_rnw    <= 1'b1;
      dram_addr   <= '0;
      dram_bsel   <= '0;
      dram_wrdata <= '0;
    end else if (c3) begin
      grant    <= grant_nxt;
      dram_req <= (grant_nxt != GNT_NONE);
      case (grant_nxt)
        GNT_VID: begin
          dram_rnw  <= 1'b1;
          dram_addr <= vid_addr;
          dram_bsel <= 2'b00;
        end
        GNT_CPU: begin
          dram_rnw  <= cpu_rnw;
          dram_addr <= cpu_addr;
          if (cpu_rnw) begin
            dram_bsel <= 2'b00;
          end else begin
            dram_bsel   <= cpu_wrbsel ? 2'b10 : 2'b01;
            dram_wrdata <= {cpu_wrdata, cpu_wrdata};
          end
        end
        GNT_DMA: begin
          dram_rnw  <= dma_rnw;
          dram_addr <= dma_addr;
          if (dma_rnw) begin
            dram_bsel <= 2'b00;
          end else begin
            dram_bsel   <= 2'b11;
            dram_wrdata <= dma_wrdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_rd_slot = (grant == GNT_CPU) && dram_rnw;

  // Read data is captured at the c2 edge so strobes land in c3; cpu_latch stretches into the next c0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_strobe <= 1'b0;
      cpu_strobe <= 1'b0;
      dma_strobe <= 1'b0;
      cpu_latch  <= 1'b0;
      cpu_rddata <= '0;
      dma_rddata <= '0;
    end else begin
      vid_strobe <= c2 && (grant == GNT_VID);
      cpu_strobe <= c2 && cpu_rd_slot;
      dma_strobe <= c2 && (grant == GNT_DMA);
      if (c2 && cpu_rd_slot)
        cpu_rddata <= dram_rddata;
      if (c2 && (grant == GNT_DMA) && dram_rnw)
        dma_rddata <= dram_rddata;
      if (c2 && cpu_rd_slot)
        cpu_latch <= 1'b1;
      else if (c0 || c1)
        cpu_latch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dram_arb.sv
// tb_dram_arb: slot-level randomized bench for dram_arb against a per-slot behavioural model.
// Build with +define+DRAM_ARB_FAIR_EN to check the fairness variant.
module tb_dram_arb;

  localparam int unsigned FAIR_LIMIT = 4;
`ifdef DRAM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        c0 = 1'b1, c1 = 1'b0, c2 = 1'b0, c3 = 1'b0;
  logic        vid_slot = 1'b0;
  logic [20:0] vid_addr = '0;
  logic        vid_strobe;
  logic        cpu_req = 1'b0, cpu_rnw = 1'b1, cpu_wrbsel = 1'b0;
  logic [20:0] cpu_addr = '0;
  logic [7:0]  cpu_wrdata = '0;
  logic        cpu_next, cpu_strobe, cpu_latch;
  logic [15:0] cpu_rddata;
  logic        dma_req = 1'b0, dma_rnw = 1'b1;
  logic [20:0] dma_addr = '0;
  logic [15:0] dma_wrdata = '0;
  logic        dma_next, dma_strobe;
  logic [15:0] dma_rddata;
  logic        dram_req, dram_rnw;
  logic [20:0] dram_addr;
  logic [1:0]  dram_bsel;
  logic [15:0] dram_wrdata;
  logic [15:0] dram_rddata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  dram_arb #(.FAIR_LIMIT(FAIR_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .vid_slot(vid_slot), .vid_addr(vid_addr), .vid_strobe(vid_strobe),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wrbsel(cpu_wrbsel),
    .cpu_wrdata(cpu_wrdata), .cpu_next(cpu_next), .cpu_strobe(cpu_strobe),
    .cpu_latch(cpu_latch), .cpu_rddata(cpu_rddata),
    .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wrdata(dma_wrdata),
    .dma_next(dma_next), .dma_strobe(dma_strobe), .dma_rddata(dma_rddata),
    .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_addr(dram_addr), .dram_bsel(dram_bsel),
    .dram_wrdata(dram_wrdata), .dram_rddata(dram_rddata)
  );

  always #5 clk = ~clk;

  // Everything observable about one slot, as seen from the c3 cycle before it to its own c3 cycle.
  typedef struct packed {
    logic        nxt_cpu;
    logic        nxt_dma;
    logic        req;
    logic        rnw;
    logic [20:0] addr;
    logic [1:0]  bsel;
    logic [15:0] wrdata;
    logic        latch_c0;
    logic        early;
    logic [20:0] addr_c3;
    logic        vid_stb;
    logic        cpu_stb;
    logic        dma_stb;
    logic        latch_c3;
    logic [15:0] cpu_rd;
    logic [15:0] dma_rd;
  } slot_t;

  slot_t e, o;
  logic [15:0] rd_val;

  int unsigned m_cnt;
  logic        m_rnw;
  logic [20:0] m_addr;
  logic [1:0]  m_bsel;
  logic [15:0] m_wr;
  bit          m_wr_known;
  logic [15:0] m_cpu_rd, m_dma_rd;
  bit          m_prev_cpu_rd;

  task automatic model_reset();
    m_cnt = 0; m_rnw = 1'b1; m_addr = '0; m_bsel = '0; m_wr = '0; m_wr_known = 0;
    m_cpu_rd = '0; m_dma_rd = '0; m_prev_cpu_rd = 0;
  endtask

  // Slot owner: 0 none, 1 video, 2 CPU, 3 DMA.
  task automatic model_slot(output slot_t x);
    bit starve;
    int w;
    starve = FAIR && dma_req && (m_cnt >= FAIR_LIMIT);
    x = '0;
    x.nxt_cpu = !vid_slot && !starve;
    x.nxt_dma = !vid_slot && (!cpu_req || starve);
    if (vid_slot)     w = 1;
    else if (starve)  w = 3;
    else if (cpu_req) w = 2;
    else if (dma_req) w = 3;
    else              w = 0;
    if (FAIR) begin
      if (!dma_req || w == 3) m_cnt = 0;
      else if (w == 2)        m_cnt = m_cnt + 1;
    end
    x.latch_c0 = m_prev_cpu_rd;
    case (w)
      1: begin m_rnw = 1'b1; m_addr = vid_addr; m_bsel = 2'b00; end
      2: begin
        m_rnw = cpu_rnw; m_addr = cpu_addr;
        m_bsel = cpu_rnw ? 2'b00 : (cpu_wrbsel ? 2'b10 : 2'b01);
        if (!cpu_rnw) begin m_wr = {cpu_wrdata, cpu_wrdata}; m_wr_known = 1; end
      end
      3: begin
        m_rnw = dma_rnw; m_addr = dma_addr;
        m_bsel = dma_rnw ? 2'b00 : 2'b11;
        if (!dma_rnw) begin m_wr = dma_wrdata; m_wr_known = 1; end
      end
      default: ;
    endcase
    x.req = (w != 0); x.rnw = m_rnw; x.addr = m_addr; x.bsel = m_bsel;
    x.wrdata = m_wr_known ? m_wr : 16'h0;
    x.addr_c3 = m_addr;
    x.vid_stb = (w == 1);
    x.cpu_stb = (w == 2) && m_rnw;
    x.dma_stb = (w == 3);
    x.latch_c3 = (w == 2) && m_rnw;
    if (w == 2 && m_rnw) m_cpu_rd = rd_val;
    if (w == 3 && m_rnw) m_dma_rd = rd_val;
    x.cpu_rd = m_cpu_rd;
    x.dma_rd = m_dma_rd;
    m_prev_cpu_rd = (w == 2) && m_rnw;
  endtask

  // Finish the cycle of phase p and present the next phase.
  task automatic cyc(input int p);
    @(posedge clk); #1;
    {c3, c2, c1, c0} = 4'b0001 << ((p + 1) % 4);
  endtask

  task automatic set_req(input bit v, input bit cr, input bit crnw, input logic [20:0] ca,
                         input bit cb, input logic [7:0] cw, input bit dr, input bit drnw,
                         input logic [20:0] da, input logic [15:0] dw);
    vid_slot = v; vid_addr = 21'($urandom);
    cpu_req = cr; cpu_rnw = crnw; cpu_addr = ca; cpu_wrbsel = cb; cpu_wrdata = cw;
    dma_req = dr; dma_rnw = drnw; dma_addr = da; dma_wrdata = dw;
  endtask

  // Called in a c3 cycle with requests applied; returns in the c3 cycle of the granted slot.
  task automatic run_slot(output slot_t x);
    x = '0;
    #1;
    x.nxt_cpu = cpu_next; x.nxt_dma = dma_next;
    cyc(3);
    x.req = dram_req; x.rnw = dram_rnw; x.addr = dram_addr; x.bsel = dram_bsel;
    x.wrdata = m_wr_known ? dram_wrdata : 16'h0;
    x.latch_c0 = cpu_latch;
    x.early = vid_strobe | cpu_strobe | dma_strobe;
    {vid_slot, cpu_req, dma_req, cpu_rnw, dma_rnw, cpu_wrbsel} = 6'($urandom);
    vid_addr = 21'($urandom); cpu_addr = 21'($urandom); dma_addr = 21'($urandom);
    cpu_wrdata = 8'($urandom); dma_wrdata = 16'($urandom);
    cyc(0);
    x.early = x.early | vid_strobe | cpu_strobe | dma_strobe | cpu_latch;
    cyc(1);
    x.early = x.early | vid_strobe | cpu_strobe | dma_strobe | cpu_latch;
    dram_rddata = rd_val;
    cyc(2);
    dram_rddata = 16'($urandom);
    x.addr_c3 = dram_addr;
    x.vid_stb = vid_strobe; x.cpu_stb = cpu_strobe; x.dma_stb = dma_strobe;
    x.latch_c3 = cpu_latch;
    x.cpu_rd = cpu_rddata; x.dma_rd = dma_rddata;
  endtask

  task automatic test_reset();
    logic [60:0] r;
    #2 rst_n = 1'b0;
    #1;
    r = {dram_req, dram_rnw, dram_addr, dram_bsel, cpu_strobe, dma_strobe, vid_strobe,
         cpu_latch, cpu_rddata, dma_rddata};
    n_checks++;
    if (r !== {1'b0, 1'b1, 21'd0, 2'd0, 4'd0, 16'd0, 16'd0}) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", r, {1'b0, 1'b1, 59'd0});
    end
    model_reset();
    cyc(0); cyc(1); cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_read();
    set_req(0, 1, 1, 21'h01234, 0, 8'h00, 0, 1, 21'h0, 16'h0);
    rd_val = 16'hBEEF;
    model_slot(e); run_slot(o);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL cpu_read_slot: got %h want %h", o, e); end
    n_checks++;
    if ({o.req, o.addr, o.cpu_rd, o.cpu_stb, o.latch_c3} !== {1'b1, 21'h01234, 16'hBEEF, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL cpu_read_fixed: got req=%b addr=%h rd=%h stb=%b latch=%b want 1 01234 beef 1 1",
                         o.req, o.addr, o.cpu_rd, o.cpu_stb, o.latch_c3);
    end
    set_req(0, 0, 1, 21'h0, 0, 8'h0, 0, 1, 21'h0, 16'h0);
    rd_val = 16'h0F0F;
    model_slot(e); run_slot(o);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL idle_after_read: got %h want %h", o, e); end
    n_checks++;
    if ({o.latch_c0, o.req} !== 2'b10) begin
      n_fail++; $display("FAIL cpu_latch_tail: got latch_c0=%b req=%b want 1 0", o.latch_c0, o.req);
    end
  endtask

  task automatic test_video_priority();
    set_req(1, 1, 1, 21'h0AAAA, 0, 8'h0, 0, 1, 21'h0, 16'h0);
    rd_val = 16'h7777;
    model_slot(e); run_slot(o);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL video_slot: got %h want %h", o, e); end
    n_checks++;
    if ({o.nxt_cpu, o.vid_stb, o.cpu_stb} !== 3'b010) begin
      n_fail++; $display("FAIL video_over_cpu: got next=%b vstb=%b cstb=%b want 0 1 0", o.nxt_cpu, o.vid_stb, o.cpu_stb);
    end
    set_req(0, 1, 1, 21'h0AAAA, 0, 8'h0, 0, 1, 21'h0, 16'h0);
    rd_val = 16'h8888;
    model_slot(e); run_slot(o);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL cpu_after_video: got %h want %h", o, e); end
  endtask

  task automatic test_cpu_write();
    for (int unsigned b = 0; b < 2; b++) begin
      set_req(0, 1, 0, 21'h1F00F, b[0], 8'h5A, 0, 1, 21'h0, 16'h0);
      rd_val = 16'h1111;
      model_slot(e); run_slot(o);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL cpu_write_slot: got %h want %h", o, e); end
      n_checks++;
      if ({o.rnw, o.wrdata, o.bsel, o.cpu_stb} !== {1'b0, 16'h5A5A, (b[0] ? 2'b10 : 2'b01), 1'b0}) begin
        n_fail++; $display("FAIL cpu_write_fixed: got rnw=%b wd=%h bsel=%b stb=%b (wrbsel %0d)",
                           o.rnw, o.wrdata, o.bsel, o.cpu_stb, b);
      end
    end
  endtask

  task automatic test_fairness();
    bit got_dma;
    set_req(0, 0, 1, 21'h0, 0, 8'h0, 0, 1, 21'h0, 16'h0);
    rd_val = 16'h0;
    model_slot(e); run_slot(o);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL fair_idle: got %h want %h", o, e); end
    for (int k = 0; k < 10; k++) begin
      set_req(0, 1, 1, 21'h00100, 0, 8'h0, 1, 1, 21'h00200, 16'h0);
      rd_val = 16'($urandom);
      model_slot(e); run_slot(o);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL fair_slot%0d: got %h want %h", k + 1, o, e); end
      got_dma = o.req && (o.addr == 21'h00200) && o.dma_stb;
      n_checks++;
      if (got_dma !== (FAIR && (k % 5 == 4))) begin
        n_fail++; $display("FAIL fair_winner%0d: got dma=%b want %b", k + 1, got_dma, FAIR && (k % 5 == 4));
      end
    end
  endtask

  task automatic test_dma();
    set_req(0, 0, 1, 21'h0, 0, 8'h0, 1, 1, 21'h05555, 16'h0);
    rd_val = 16'h1234;
    model_slot(e); run_slot(o);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL dma_read_slot: got %h want %h", o, e); end
    n_checks++;
    if ({o.dma_rd, o.dma_stb, o.cpu_stb} !== {16'h1234, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL dma_read_fixed: got rd=%h stb=%b cstb=%b want 1234 1 0", o.dma_rd, o.dma_stb, o.cpu_stb);
    end
    set_req(0, 1, 0, 21'h00042, 0, 8'hC3, 1, 0, 21'h05555, 16'hA55A);
    rd_val = 16'h2222;
    model_slot(e); run_slot(o);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL dma_blocked: got %h want %h", o, e); end
    n_checks++;
    if (o.nxt_dma !== 1'b0) begin n_fail++; $display("FAIL dma_next_cpu: got %b want 0", o.nxt_dma); end
    set_req(0, 0, 1, 21'h0, 0, 8'h0, 1, 0, 21'h05556, 16'hA55A);
    model_slot(e); run_slot(o);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL dma_write_slot: got %h want %h", o, e); end
    n_checks++;
    if ({o.bsel, o.wrdata, o.dma_stb} !== {2'b11, 16'hA55A, 1'b1}) begin
      n_fail++; $display("FAIL dma_write_fixed: got bsel=%b wd=%h stb=%b want 11 a55a 1", o.bsel, o.wrdata, o.dma_stb);
    end
  endtask

  task automatic test_reset_mid_slot();
    logic [60:0] r;
    set_req(0, 1, 1, 21'h0ABCD, 0, 8'h0, 0, 1, 21'h0, 16'h0);
    cyc(3); cyc(0);
    #2 rst_n = 1'b0;
    #1;
    r = {dram_req, dram_rnw, dram_addr, dram_bsel, cpu_strobe, dma_strobe, vid_strobe,
         cpu_latch, cpu_rddata, dma_rddata};
    n_checks++;
    if (r !== {1'b0, 1'b1, 21'd0, 2'd0, 4'd0, 16'd0, 16'd0}) begin
      n_fail++; $display("FAIL reset_mid_slot: got %h want %h", r, {1'b0, 1'b1, 59'd0});
    end
    model_reset();
    cyc(1);
    #2 rst_n = 1'b1;
    dram_rddata = 16'h4321;
    cyc(2);
    n_checks++;
    if ({cpu_strobe, cpu_latch, cpu_rddata, dram_req} !== {1'b0, 1'b0, 16'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset_no_strobe: got stb=%b latch=%b rd=%h req=%b want 0 0 0000 0",
                         cpu_strobe, cpu_latch, cpu_rddata, dram_req);
    end
    set_req(0, 1, 1, 21'h0ABCD, 0, 8'h0, 0, 1, 21'h0, 16'h0);
    rd_val = 16'hCAFE;
    model_slot(e); run_slot(o);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL grant_after_reset: got %h want %h", o, e); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      set_req(($urandom_range(3) == 0), 1'($urandom), 1'($urandom), 21'($urandom), 1'($urandom),
              8'($urandom), 1'($urandom), 1'($urandom), 21'($urandom), 16'($urandom));
      rd_val = 16'($urandom);
      model_slot(e); run_slot(o);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL random_slot%0d: got %h want %h", k, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_video_priority();
    test_cpu_write();
    test_fairness();
    test_dma();
    test_reset_mid_slot();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
